// File: rtl/buffer_write_controller.sv
// Fills a ping-pong (2-bank) buffer from a valid/ready stream by sequencing an
// external write-address generator (start / count_up / clear) and tracking
// per-bank full flags until NUM_BLOCKS blocks have been written.
module buffer_write_controller #(
  parameter int unsigned BUFFER_ADDRESS_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] len_i,
  input  logic [7:0]  num_blocks_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        wr_en_o,
  output logic        wr_bank_o,
  output logic        gen_start_o,
  output logic        gen_count_up_o,
  output logic        gen_clear_o,
  input  logic [15:0] gen_global_counts_i,
  output logic [1:0]  bank_full_o,
  input  logic [1:0]  bank_release_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned NB_W  = 8;
  // One extra bit so a full bank of 2**AW words is representable.
  localparam int unsigned LQ_W  = LEN_W + 1;
  localparam logic [LQ_W-1:0] BANK_WORDS = LQ_W'(64'(1) << BUFFER_ADDRESS_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SWITCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LQ_W-1:0]   len_q, len_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [NB_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [1:0]        bank_set;
  logic              in_ready_q, gen_clear_q, busy_q, done_q;
  logic              zero_done;

  logic              start_acc;
  logic              start_zero;
  logic              wr_en;
  logic              last_word;
  logic [LQ_W-1:0]   len_ext;
  logic [1:0]        bank_full_post;
  logic              next_bank;

  // Handshake and last-word detection against the generator's global count.
  always_comb begin
    start_acc      = (state_q == S_IDLE) && start_i;
    start_zero     = (len_i == LEN_W'(0)) || (num_blocks_i == NB_W'(0));
    wr_en          = in_valid_i && in_ready_q;
    last_word      = wr_en && ({1'b0, gen_global_counts_i} == (len_q - LQ_W'(1)));
    len_ext        = {1'b0, len_i};
    bank_full_post = bank_full_q & ~bank_release_i;
    next_bank      = ~wr_bank_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath-next logic.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    nb_d      = nb_q;
    blk_cnt_d = blk_cnt_q;
    wr_bank_d = wr_bank_q;
    bank_set  = 2'b00;
    zero_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          len_d = (len_ext > BANK_WORDS) ? BANK_WORDS : len_ext;
          nb_d  = num_blocks_i;
          if (start_zero) begin
            zero_done = 1'b1;
          end else begin
            state_d   = S_FILL;
            wr_bank_d = 1'b0;
            blk_cnt_d = NB_W'(0);
          end
        end
      end
      S_FILL: begin
        if (last_word) begin
          bank_set  = wr_bank_q ? 2'b10 : 2'b01;
          blk_cnt_d = blk_cnt_q + NB_W'(1);
          state_d   = S_SWITCH;
        end
      end
      S_SWITCH: begin
        if (blk_cnt_q == nb_q) begin
          state_d = S_DONE;
        end else begin
          wr_bank_d = next_bank;
          // A release landing in this same cycle frees the next bank.
          state_d   = bank_full_post[next_bank] ? S_WAIT : S_FILL;
        end
      end
      S_WAIT: begin
        if (!bank_full_q[wr_bank_q]) state_d = S_FILL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Releases of non-full banks are harmless; a same-cycle set wins.
    bank_full_d = (bank_full_q & ~bank_release_i) | bank_set;
  end

  // Datapath and registered state-derived outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      nb_q        <= '0;
      blk_cnt_q   <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      in_ready_q  <= 1'b0;
      gen_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      len_q       <= len_d;
      nb_q        <= nb_d;
      blk_cnt_q   <= blk_cnt_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      in_ready_q  <= (state_d == S_FILL);
      gen_clear_q <= (state_d == S_SWITCH);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE) || zero_done;
    end
  end

  // Output mapping; write strobe and generator start are same-cycle handshakes.
  always_comb begin
    in_ready_o     = in_ready_q;
    wr_en_o        = wr_en;
    gen_count_up_o = wr_en;
    gen_start_o    = start_acc;
    gen_clear_o    = gen_clear_q;
    wr_bank_o      = wr_bank_q;
    bank_full_o    = bank_full_q;
    busy_o         = busy_q;
    done_o         = done_q;
  end

endmodule

// File: tb/tb_buffer_write_controller.sv
// Directed bench for buffer_write_controller with a behavioural address generator.
module tb_buffer_write_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [7:0]  num_blocks_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o, wr_en_o, wr_bank_o, gen_start_o, gen_count_up_o, gen_clear_o;
  logic [15:0] gen_global_counts_i;
  logic [1:0]  bank_full_o;
  logic [1:0]  bank_release_i = 2'b00;
  logic        busy_o, done_o;
  logic [15:0] gen_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  buffer_write_controller #(.BUFFER_ADDRESS_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .len_i(len_i),
    .num_blocks_i(num_blocks_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .gen_start_o(gen_start_o),
    .gen_count_up_o(gen_count_up_o), .gen_clear_o(gen_clear_o),
    .gen_global_counts_i(gen_global_counts_i), .bank_full_o(bank_full_o),
    .bank_release_i(bank_release_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Address generator stand-in: counts write strobes, zeroed by start or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        gen_cnt <= '0;
    else if (gen_start_o || gen_clear_o) gen_cnt <= '0;
    else if (gen_count_up_o)             gen_cnt <= gen_cnt + 16'd1;
  end
  assign gen_global_counts_i = gen_cnt;

  task automatic test_reset();
    @(negedge clk); in_valid_i = 1'b1; #1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
    n_cmp++; if (wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o); end
    n_cmp++; if (bank_full_o !== 2'b00) begin n_fail++; $display("FAIL reset_bank_full: got %b want 00", bank_full_o); end
    n_cmp++; if ({busy_o, done_o, gen_clear_o, gen_start_o, wr_bank_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_misc: got %b want 00000", {busy_o, done_o, gen_clear_o, gen_start_o, wr_bank_o}); end
    @(negedge clk); reset_n = 1'b1; in_valid_i = 1'b0;
  endtask

  task automatic release_banks(input logic [1:0] b);
    @(negedge clk); bank_release_i = b;
    @(negedge clk); bank_release_i = 2'b00;
  endtask

  task automatic test_single_block();
    int nw = 0; int nclr = 0; int ndone = 0; int nstart = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd4; num_blocks_i = 8'd1; in_valid_i = 1'b1; #1;
    n_cmp++; if (gen_start_o !== 1'b1) begin n_fail++; $display("FAIL single_gen_start: got %b want 1", gen_start_o); end
    @(negedge clk); start_i = 1'b0; #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready_latency: got %b want 1", in_ready_o); end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (wr_en_o) begin
        n_cmp++; if (gen_global_counts_i !== 16'(nw)) begin n_fail++; $display("FAIL single_count: got %0d want %0d", gen_global_counts_i, nw); end
        nw++;
      end
      if (gen_clear_o) nclr++;
      if (done_o) ndone++;
      if (gen_start_o) nstart++;
    end
    n_cmp++; if (nw != 4) begin n_fail++; $display("FAIL single_writes: got %0d want 4", nw); end
    n_cmp++; if (nclr != 1) begin n_fail++; $display("FAIL single_clears: got %0d want 1", nclr); end
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", ndone); end
    n_cmp++; if (nstart != 0) begin n_fail++; $display("FAIL single_extra_start: got %0d want 0", nstart); end
    n_cmp++; if (bank_full_o !== 2'b01) begin n_fail++; $display("FAIL single_bank_full: got %b want 01", bank_full_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy_o); end
    release_banks(2'b01); #1;
    n_cmp++; if (bank_full_o !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", bank_full_o); end
  endtask

  task automatic test_ping_pong();
    int nw = 0; int ndone = 0; int badbank = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd3; num_blocks_i = 8'd3; in_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (wr_en_o) begin
        if (wr_bank_o !== logic'((nw / 3) % 2)) badbank++;
        n_cmp++; if (gen_global_counts_i !== 16'(nw % 3)) begin n_fail++; $display("FAIL pp_count: got %0d want %0d", gen_global_counts_i, nw % 3); end
        nw++;
      end
      if (done_o) ndone++;
    end
    n_cmp++; if (nw != 6) begin n_fail++; $display("FAIL pp_writes_before_wait: got %0d want 6", nw); end
    n_cmp++; if (badbank != 0) begin n_fail++; $display("FAIL pp_bank_order: got %0d wrong want 0", badbank); end
    n_cmp++; if ({in_ready_o, busy_o, wr_bank_o, ndone != 0} !== 4'b0100) begin
      n_fail++; $display("FAIL pp_wait_state: got ready/busy/bank/done=%b want 0100", {in_ready_o, busy_o, wr_bank_o, ndone != 0}); end
    n_cmp++; if (bank_full_o !== 2'b11) begin n_fail++; $display("FAIL pp_both_full: got %b want 11", bank_full_o); end
    @(negedge clk); bank_release_i = 2'b01; #1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL pp_ready_at_release: got %b want 0", in_ready_o); end
    @(negedge clk); bank_release_i = 2'b00; #1;
    n_cmp++; if ({bank_full_o, in_ready_o} !== 3'b100) begin n_fail++; $display("FAIL pp_cleared_waiting: got %b want 100", {bank_full_o, in_ready_o}); end
    nw = 0; badbank = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin @(negedge clk); end
      else begin @(negedge clk); end
      #1;
      if (i == 0) begin
        n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_resume_ready: got %b want 1", in_ready_o); end
      end
      if (wr_en_o) begin
        if (wr_bank_o !== 1'b0) badbank++;
        n_cmp++; if (gen_global_counts_i !== 16'(nw)) begin n_fail++; $display("FAIL pp_third_count: got %0d want %0d", gen_global_counts_i, nw); end
        nw++;
      end
      if (done_o) ndone++;
    end
    n_cmp++; if (nw != 3 || badbank != 0) begin n_fail++; $display("FAIL pp_third_block: got %0d writes %0d badbank want 3 0", nw, badbank); end
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL pp_done: got %0d want 1", ndone); end
    n_cmp++; if ({bank_full_o, busy_o} !== 3'b110) begin n_fail++; $display("FAIL pp_end_flags: got %b want 110", {bank_full_o, busy_o}); end
    release_banks(2'b11); #1;
    n_cmp++; if (bank_full_o !== 2'b00) begin n_fail++; $display("FAIL pp_release_both: got %b want 00", bank_full_o); end
  endtask

  task automatic test_gappy();
    logic [5:0] pat = 6'b101001;
    int nw = 0; int bad_wr = 0; int early_clr = 0; int ndone = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd5; num_blocks_i = 8'd1; in_valid_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); start_i = 1'b0; in_valid_i = pat[i % 6]; #1;
      if (wr_en_o && !in_valid_i) bad_wr++;
      if (gen_clear_o && nw < 5) early_clr++;
      if (wr_en_o) begin
        n_cmp++; if (gen_global_counts_i !== 16'(nw)) begin n_fail++; $display("FAIL gap_count: got %0d want %0d", gen_global_counts_i, nw); end
        nw++;
      end
      if (done_o) ndone++;
    end
    in_valid_i = 1'b0;
    n_cmp++; if (nw != 5) begin n_fail++; $display("FAIL gap_writes: got %0d want 5", nw); end
    n_cmp++; if (bad_wr != 0) begin n_fail++; $display("FAIL gap_wr_without_valid: got %0d want 0", bad_wr); end
    n_cmp++; if (early_clr != 0) begin n_fail++; $display("FAIL gap_early_clear: got %0d want 0", early_clr); end
    n_cmp++; if (ndone != 1) begin n_fail++; $display("FAIL gap_done: got %0d want 1", ndone); end
    release_banks(2'b01);
  endtask

  task automatic test_clamp();
    int nw = 0; int last_cnt = -1; bit prev_last = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd2000; num_blocks_i = 8'd1; in_valid_i = 1'b1;
    for (int i = 0; i < 1040; i++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (prev_last) begin
        n_cmp++; if ({bank_full_o, gen_clear_o} !== 3'b011) begin n_fail++; $display("FAIL clamp_full_after_last: got %b want 011", {bank_full_o, gen_clear_o}); end
        prev_last = 0;
      end
      if (wr_en_o) begin
        last_cnt = int'(gen_global_counts_i); nw++;
        if (nw == 1024) begin
          prev_last = 1;
          n_cmp++; if (bank_full_o !== 2'b00) begin n_fail++; $display("FAIL clamp_full_early: got %b want 00", bank_full_o); end
        end
      end
    end
    n_cmp++; if (nw != 1024) begin n_fail++; $display("FAIL clamp_writes: got %0d want 1024", nw); end
    n_cmp++; if (last_cnt != 1023) begin n_fail++; $display("FAIL clamp_last_count: got %0d want 1023", last_cnt); end
    release_banks(2'b01);
  endtask

  task automatic test_zero_and_busy_start();
    int nw = 0; int ndone = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd0; num_blocks_i = 8'd5; in_valid_i = 1'b1; #1;
    n_cmp++; if (gen_start_o !== 1'b1) begin n_fail++; $display("FAIL zero_gen_start: got %b want 1", gen_start_o); end
    @(negedge clk); start_i = 1'b0; #1;
    n_cmp++; if ({done_o, busy_o, in_ready_o} !== 3'b100) begin n_fail++; $display("FAIL zero_len_done: got %b want 100", {done_o, busy_o, in_ready_o}); end
    @(negedge clk); start_i = 1'b1; len_i = 16'd3; num_blocks_i = 8'd0; #1;
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %b want 0", done_o); end
    @(negedge clk); start_i = 1'b0; #1;
    n_cmp++; if ({done_o, busy_o} !== 2'b10) begin n_fail++; $display("FAIL zero_nb_done: got %b want 10", {done_o, busy_o}); end
    @(negedge clk); start_i = 1'b1; len_i = 16'd2; num_blocks_i = 8'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start_i = (i == 1); len_i = 16'd9; #1;
      if (i == 1) begin
        n_cmp++; if (gen_start_o !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: got %b want 0", gen_start_o); end
      end
      if (wr_en_o) nw++;
      if (done_o) ndone++;
    end
    start_i = 1'b0;
    n_cmp++; if (nw != 2 || ndone != 1) begin n_fail++; $display("FAIL busy_start_transfer: got %0d writes %0d done want 2 1", nw, ndone); end
    release_banks(2'b01);
  endtask

  task automatic test_reset_mid_fill();
    int nw = 0; int ndone = 0; bit hit = 0;
    @(negedge clk); start_i = 1'b1; len_i = 16'd8; num_blocks_i = 8'd1; in_valid_i = 1'b1;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (wr_en_o && gen_global_counts_i == 16'd2) hit = 1;
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL rst_reach_count2: got no write at count 2 want one"); end
    #1 reset_n = 1'b0; #1;
    n_cmp++; if ({in_ready_o, wr_en_o, busy_o, done_o, gen_clear_o, wr_bank_o, bank_full_o} !== 8'b0) begin
      n_fail++; $display("FAIL rst_async_outputs: got %b want 00000000", {in_ready_o, wr_en_o, busy_o, done_o, gen_clear_o, wr_bank_o, bank_full_o}); end
    @(negedge clk); reset_n = 1'b1; #1;
    n_cmp++; if ({busy_o, in_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rst_idle_after: got %b want 00", {busy_o, in_ready_o}); end
    @(negedge clk); start_i = 1'b1; len_i = 16'd2; num_blocks_i = 8'd1; #1;
    n_cmp++; if (gen_start_o !== 1'b1) begin n_fail++; $display("FAIL rst_restart: got %b want 1", gen_start_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start_i = 1'b0; #1;
      if (wr_en_o) begin
        n_cmp++; if (gen_global_counts_i !== 16'(nw)) begin n_fail++; $display("FAIL rst_restart_count: got %0d want %0d", gen_global_counts_i, nw); end
        nw++;
      end
      if (done_o) ndone++;
    end
    n_cmp++; if (nw != 2 || ndone != 1) begin n_fail++; $display("FAIL rst_restart_transfer: got %0d writes %0d done want 2 1", nw, ndone); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_ping_pong();
    test_gappy();
    test_clamp();
    test_zero_and_busy_start();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
